// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter sharing one I2C byte-write engine between NUM_REQ requesters.
// Optional NACK re-issue is built when the I2C_RETRY_EN macro is defined.
module i2c_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_done,
    output logic [NUM_REQ-1:0]   rsp_nack,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 eng_start,
    output logic [6:0]           eng_addr,
    output logic [7:0]           eng_data,
    input  logic                 eng_busy,
    input  logic                 eng_done,
    input  logic                 eng_nack
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_RETRY < 0) begin : g_bad_param
        $error("i2c_write_arbiter: NUM_REQ must be 2..8 and MAX_RETRY non-negative");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   last_grant_r;
    logic [IW-1:0]   gnt_r;
    logic [IW-1:0]   pick_s;
    logic            any_s;
    logic [6:0]      addr_arr_s [NUM_REQ];
    logic [7:0]      data_arr_s [NUM_REQ];

`ifdef I2C_RETRY_EN
    localparam int RW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    logic [RW-1:0]   retry_cnt_r;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign addr_arr_s[i] = req_addr[7*i +: 7];
        assign data_arr_s[i] = req_data[8*i +: 8];
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [IW-1:0] idx_s;
        any_s  = 1'b0;
        pick_s = '0;
        idx_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = IW'((int'(last_grant_r) + k) % NUM_REQ);
            if (!any_s && req_valid[idx_s]) begin
                any_s  = 1'b1;
                pick_s = idx_s;
            end else begin
                any_s  = any_s;
            end
        end
    end

    // Transaction sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= IW'(NUM_REQ - 1);
            gnt_r        <= '0;
            req_ready    <= '0;
            rsp_done     <= '0;
            rsp_nack     <= '0;
            grant_id     <= 3'd0;
            active       <= 1'b0;
            eng_start    <= 1'b0;
            eng_addr     <= 7'd0;
            eng_data     <= 8'd0;
`ifdef I2C_RETRY_EN
            retry_cnt_r  <= '0;
`endif
        end else begin
            req_ready <= '0;
            rsp_done  <= '0;
            rsp_nack  <= '0;
            eng_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        req_ready[pick_s] <= 1'b1;
                        gnt_r             <= pick_s;
                        grant_id          <= 3'(pick_s);
                        active            <= 1'b1;
                        eng_addr          <= addr_arr_s[pick_s];
                        eng_data          <= data_arr_s[pick_s];
                        state_r           <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!eng_busy) begin
                        eng_start <= 1'b1;
                        state_r   <= ST_WAIT;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (eng_done) begin
`ifdef I2C_RETRY_EN
                        // A NACK with attempts left re-issues the same byte silently.
                        if (eng_nack && (retry_cnt_r < RETRY_LIM)) begin
                            retry_cnt_r <= retry_cnt_r + RW'(1);
                            state_r     <= ST_ISSUE;
                        end else begin
                            rsp_done[gnt_r] <= 1'b1;
                            rsp_nack[gnt_r] <= eng_nack;
                            state_r         <= ST_DONE;
                        end
`else
                        rsp_done[gnt_r] <= 1'b1;
                        rsp_nack[gnt_r] <= eng_nack;
                        state_r         <= ST_DONE;
`endif
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    last_grant_r <= gnt_r;
                    active       <= 1'b0;
                    state_r      <= ST_IDLE;
`ifdef I2C_RETRY_EN
                    retry_cnt_r  <= '0;
`endif
                end
                default: begin
                    active  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
